wb_commit_stage: RTL and testbench

//  Final (writeback/commit) pipeline stage: latches one retiring instruction from MEM, writes GPR and CSR,
//  and commits exceptions/ertn. On a trapping instruction it suppresses all architectural writes,

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_commit_stage_if.sv | 42 ++++
 rtl/wb_flush_ctrl.sv | 64 ++++++
 rtl/wb_commit_stage.sv | 128 ++++++++++++
 tb/tb_wb_commit_stage.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/commit stage: exception codes,
// the esubcode width and the flush-control state encoding.
package wb_pkg;

    localparam int ESUBCODE_W = 9;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_commit_stage_if.sv
// MEM -> WB instruction handoff. Every ms_* field rides with ms_to_ws_valid.
// An instruction moves into WB on a rising edge where ms_to_ws_valid and ws_allowin are both 1.
// MEM may drop or change its offer freely while ws_allowin is 0.
interface wb_commit_stage_if #(
    parameter int DATA_W  = 32,
    parameter int RF_AW   = 5,
    parameter int CSR_AW  = 14,
    parameter int ECODE_W = 6
);
    import wb_pkg::*;

    logic                  ms_to_ws_valid;
    logic [DATA_W-1:0]     ms_pc;
    logic                  ms_gr_we;
    logic [RF_AW-1:0]      ms_dest;
    logic [DATA_W-1:0]     ms_result;
    logic                  ms_csr_we;
    logic [CSR_AW-1:0]     ms_csr_num;
    logic [DATA_W-1:0]     ms_csr_wmask;
    logic [DATA_W-1:0]     ms_csr_wdata;
    logic                  ms_exc;
    logic [ECODE_W-1:0]    ms_ecode;
    logic [ESUBCODE_W-1:0] ms_esubcode;
    logic [DATA_W-1:0]     ms_badv;
    logic                  ms_ertn;
    logic                  ws_allowin;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
               ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wdata,
               ms_exc, ms_ecode, ms_esubcode, ms_badv, ms_ertn,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_result,
               ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wdata,
               ms_exc, ms_ecode, ms_esubcode, ms_badv, ms_ertn,
        output ws_allowin
    );

endinterface

// File: rtl/wb_flush_ctrl.sv
// Trap sequencing: one flush pulse when a trapping instruction sits in WB,
// then FLUSH_HOLD cycles of blocked allowin so the front stages can drain.
module wb_flush_ctrl
    import wb_pkg::*;
#(
    parameter int FLUSH_HOLD = 1
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      trap,
    output logic      ws_flush,
    output logic      hold_allowin,
    output wb_state_e state
);

    localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

    wb_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ws_flush     = 1'b0;
        hold_allowin = (state_q == RUN);
        case (state_q)
            RUN: begin
                if (trap) begin
                    ws_flush = 1'b1;
                    // A zero hold length skips HOLD entirely.
                    if (HOLD_INIT != 4'd0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_INIT;
                    end
                end
            end
            HOLD: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds the retiring instruction, drives GPR/CSR writes,
// commits traps and ertn, and feeds ID forwarding and the trace-debug port.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RF_AW      = 5,
    parameter int CSR_AW     = 14,
    parameter int ECODE_W    = 6,
    parameter int FLUSH_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    wb_commit_stage_if.slave      ms,
    output logic                  ws_flush,
    output logic                  ws_to_ds_valid,
    output logic [RF_AW-1:0]      ws_to_ds_dest,
    output logic [DATA_W-1:0]     ws_to_ds_result,
    output logic                  ws_to_ds_csr_busy,
    output logic                  rf_we,
    output logic [RF_AW-1:0]      rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  csr_we,
    output logic [CSR_AW-1:0]     csr_num,
    output logic [DATA_W-1:0]     csr_wmask,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic                  exc_commit,
    output logic [ECODE_W-1:0]    exc_ecode,
    output logic [ESUBCODE_W-1:0] exc_esubcode,
    output logic [DATA_W-1:0]     exc_pc,
    output logic [DATA_W-1:0]     exc_badv,
    output logic                  ertn_commit,
    output logic [DATA_W-1:0]     debug_wb_pc,
    output logic [DATA_W/8-1:0]   debug_wb_rf_we,
    output logic [RF_AW-1:0]      debug_wb_rf_wnum,
    output logic [DATA_W-1:0]     debug_wb_rf_wdata,
    output wb_state_e             dbg_state
);

    logic                  ws_valid;
    logic [DATA_W-1:0]     pc_q, result_q, csr_wmask_q, csr_wdata_q, badv_q;
    logic                  gr_we_q, csr_we_q, exc_q, ertn_q;
    logic [RF_AW-1:0]      dest_q;
    logic [CSR_AW-1:0]     csr_num_q;
    logic [ECODE_W-1:0]    ecode_q;
    logic [ESUBCODE_W-1:0] esubcode_q;
    logic                  trap, retire, hold_allowin, allowin;

    assign trap    = ws_valid & (exc_q | ertn_q);
    assign retire  = ws_valid & ~trap;
    assign allowin = hold_allowin & ~trap;
    assign ms.ws_allowin = allowin;

    wb_flush_ctrl #(.FLUSH_HOLD(FLUSH_HOLD)) u_flush_ctrl (
        .clk          (clk),
        .resetn       (resetn),
        .trap         (trap),
        .ws_flush     (ws_flush),
        .hold_allowin (hold_allowin),
        .state        (dbg_state)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid    <= 1'b0;
            pc_q        <= '0;
            gr_we_q     <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            csr_we_q    <= 1'b0;
            csr_num_q   <= '0;
            csr_wmask_q <= '0;
            csr_wdata_q <= '0;
            exc_q       <= 1'b0;
            ecode_q     <= '0;
            esubcode_q  <= '0;
            badv_q      <= '0;
            ertn_q      <= 1'b0;
        end else if (allowin) begin
            ws_valid <= ms.ms_to_ws_valid;
            if (ms.ms_to_ws_valid) begin
                pc_q        <= ms.ms_pc;
                gr_we_q     <= ms.ms_gr_we;
                dest_q      <= ms.ms_dest;
                result_q    <= ms.ms_result;
                csr_we_q    <= ms.ms_csr_we;
                csr_num_q   <= ms.ms_csr_num;
                csr_wmask_q <= ms.ms_csr_wmask;
                csr_wdata_q <= ms.ms_csr_wdata;
                exc_q       <= ms.ms_exc;
                ecode_q     <= ms.ms_ecode;
                esubcode_q  <= ms.ms_esubcode;
                badv_q      <= ms.ms_badv;
                ertn_q      <= ms.ms_ertn;
            end
        end else if (trap) begin
            ws_valid <= 1'b0;
        end
    end

    // A trapping instruction writes nothing; exc takes priority over ertn.
    assign rf_we       = retire & gr_we_q;
    assign rf_waddr    = dest_q;
    assign rf_wdata    = result_q;
    assign csr_we      = retire & csr_we_q;
    assign csr_num     = csr_num_q;
    assign csr_wmask   = csr_wmask_q;
    assign csr_wdata   = csr_wdata_q;
    assign exc_commit  = ws_flush & exc_q;
    assign ertn_commit = ws_flush & ~exc_q & ertn_q;

    assign exc_ecode    = exc_commit ? ecode_q    : '0;
    assign exc_esubcode = exc_commit ? esubcode_q : '0;
    assign exc_pc       = exc_commit ? pc_q       : '0;
    assign exc_badv     = exc_commit ? badv_q     : '0;

    // r0 writes still reach the RF but must never be forwarded.
    assign ws_to_ds_valid    = rf_we & (dest_q != '0);
    assign ws_to_ds_dest     = ws_to_ds_valid ? dest_q   : '0;
    assign ws_to_ds_result   = ws_to_ds_valid ? result_q : '0;
    assign ws_to_ds_csr_busy = ws_valid & (csr_we_q | exc_q | ertn_q);

    assign debug_wb_pc       = retire ? pc_q : '0;
    assign debug_wb_rf_we    = {(DATA_W/8){rf_we}};
    assign debug_wb_rf_wnum  = rf_we ? dest_q   : '0;
    assign debug_wb_rf_wdata = rf_we ? result_q : '0;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: three instances (FLUSH_HOLD 1, 0, 3) share one MEM-side driver;
// instance 0 is checked event-by-event, the others for stall length and async reset.
module tb_wb_commit_stage;
  import wb_pkg::*;

  localparam int NI = 3;
  localparam int FH [NI] = '{1, 0, 3};

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  dbg_we;
    logic [31:0] dbg_pc;
    logic        fwd_v;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_res;
    logic        csr_we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] cdata;
    logic        busy;
    logic        exc;
    logic        ertn;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] epc;
    logic [31:0] badv;
    logic        flush;
  } ev_t;

  localparam int EW = $bits(ev_t);

  typedef struct packed {
    logic [31:0] pc;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        csr_we;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] cdata;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic [31:0] badv;
    logic        ertn;
  } in_t;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // shared MEM-side stimulus
  logic        m_valid = 1'b0;
  in_t         m_in = '0;

  // per-instance outputs
  logic [NI-1:0] allowin, ws_flush, fwd_v, csr_busy, rf_we, csr_we, exc_commit, ertn_commit;
  logic [4:0]    fwd_dest [NI];
  logic [31:0]   fwd_res [NI];
  logic [4:0]    rf_waddr [NI];
  logic [31:0]   rf_wdata [NI];
  logic [13:0]   csr_num [NI];
  logic [31:0]   csr_wmask [NI];
  logic [31:0]   csr_wdata [NI];
  logic [5:0]    exc_ecode [NI];
  logic [8:0]    exc_esub [NI];
  logic [31:0]   exc_pc [NI];
  logic [31:0]   exc_badv [NI];
  logic [31:0]   dbg_pc [NI];
  logic [3:0]    dbg_we [NI];
  logic [4:0]    dbg_wnum [NI];
  logic [31:0]   dbg_wdata [NI];
  wb_state_e     dbg_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_commit_stage_if #(.DATA_W(32), .RF_AW(5), .CSR_AW(14), .ECODE_W(6)) u_if ();
    assign u_if.ms_to_ws_valid = m_valid;
    assign u_if.ms_pc          = m_in.pc;
    assign u_if.ms_gr_we       = m_in.gr_we;
    assign u_if.ms_dest        = m_in.dest;
    assign u_if.ms_result      = m_in.result;
    assign u_if.ms_csr_we      = m_in.csr_we;
    assign u_if.ms_csr_num     = m_in.num;
    assign u_if.ms_csr_wmask   = m_in.mask;
    assign u_if.ms_csr_wdata   = m_in.cdata;
    assign u_if.ms_exc         = m_in.exc;
    assign u_if.ms_ecode       = m_in.ecode;
    assign u_if.ms_esubcode    = m_in.esub;
    assign u_if.ms_badv        = m_in.badv;
    assign u_if.ms_ertn        = m_in.ertn;
    assign allowin[g]          = u_if.ws_allowin;

    wb_commit_stage #(.DATA_W(32), .RF_AW(5), .CSR_AW(14), .ECODE_W(6), .FLUSH_HOLD(FH[g])) u_dut (
      .clk               (clk),
      .resetn            (resetn),
      .ms                (u_if),
      .ws_flush          (ws_flush[g]),
      .ws_to_ds_valid    (fwd_v[g]),
      .ws_to_ds_dest     (fwd_dest[g]),
      .ws_to_ds_result   (fwd_res[g]),
      .ws_to_ds_csr_busy (csr_busy[g]),
      .rf_we             (rf_we[g]),
      .rf_waddr          (rf_waddr[g]),
      .rf_wdata          (rf_wdata[g]),
      .csr_we            (csr_we[g]),
      .csr_num           (csr_num[g]),
      .csr_wmask         (csr_wmask[g]),
      .csr_wdata         (csr_wdata[g]),
      .exc_commit        (exc_commit[g]),
      .exc_ecode         (exc_ecode[g]),
      .exc_esubcode      (exc_esub[g]),
      .exc_pc            (exc_pc[g]),
      .exc_badv          (exc_badv[g]),
      .ertn_commit       (ertn_commit[g]),
      .debug_wb_pc       (dbg_pc[g]),
      .debug_wb_rf_we    (dbg_we[g]),
      .debug_wb_rf_wnum  (dbg_wnum[g]),
      .debug_wb_rf_wdata (dbg_wdata[g]),
      .dbg_state         (dbg_state[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // stimulus helpers
  function automatic in_t i_alu(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res);
    in_t i = '0;
    i.pc = pc; i.gr_we = 1'b1; i.dest = dest; i.result = res;
    return i;
  endfunction

  function automatic in_t i_csr(input logic [31:0] pc, input logic [13:0] num,
                                input logic [31:0] mask, input logic [31:0] data);
    in_t i = '0;
    i.pc = pc; i.csr_we = 1'b1; i.num = num; i.mask = mask; i.cdata = data;
    return i;
  endfunction

  function automatic in_t i_trap(input logic [31:0] pc, input logic exc, input logic ertn,
                                 input logic [5:0] ecode, input logic [8:0] esub, input logic [31:0] badv);
    in_t i = '0;
    i.pc = pc; i.exc = exc; i.ertn = ertn; i.ecode = ecode; i.esub = esub; i.badv = badv;
    i.gr_we = 1'b1; i.dest = 5'd9; i.result = 32'hDEAD_BEEF; i.csr_we = 1'b1; i.num = 14'h5;
    return i;
  endfunction

  // expected-event helpers (values written out by hand in each call)
  function automatic ev_t e_rf(input logic [31:0] pc, input logic [4:0] dest, input logic [31:0] res,
                               input logic fv, input logic [4:0] fd, input logic [31:0] fr);
    ev_t e = '0;
    e.rf_we = 1'b1; e.waddr = dest; e.wdata = res; e.dbg_we = 4'hF; e.dbg_pc = pc;
    e.fwd_v = fv; e.fwd_dest = fd; e.fwd_res = fr;
    return e;
  endfunction

  function automatic ev_t e_csr(input logic [31:0] pc, input logic [13:0] num,
                                input logic [31:0] mask, input logic [31:0] data);
    ev_t e = '0;
    e.csr_we = 1'b1; e.num = num; e.mask = mask; e.cdata = data; e.busy = 1'b1; e.dbg_pc = pc;
    return e;
  endfunction

  function automatic ev_t e_trap(input logic exc, input logic ertn, input logic [5:0] ecode,
                                 input logic [8:0] esub, input logic [31:0] pc, input logic [31:0] badv);
    ev_t e = '0;
    e.exc = exc; e.ertn = ertn; e.ecode = ecode; e.esub = esub; e.epc = pc; e.badv = badv;
    e.busy = 1'b1; e.flush = 1'b1;
    return e;
  endfunction

  function automatic ev_t observe();
    ev_t e = '0;
    e.rf_we = rf_we[0];
    if (rf_we[0]) begin e.waddr = rf_waddr[0]; e.wdata = rf_wdata[0]; end
    e.dbg_we = dbg_we[0]; e.dbg_pc = dbg_pc[0];
    e.fwd_v = fwd_v[0]; e.fwd_dest = fwd_dest[0]; e.fwd_res = fwd_res[0];
    e.csr_we = csr_we[0];
    if (csr_we[0]) begin e.num = csr_num[0]; e.mask = csr_wmask[0]; e.cdata = csr_wdata[0]; end
    e.busy = csr_busy[0];
    e.exc = exc_commit[0]; e.ertn = ertn_commit[0];
    e.ecode = exc_ecode[0]; e.esub = exc_esub[0]; e.epc = exc_pc[0]; e.badv = exc_badv[0];
    e.flush = ws_flush[0];
    return e;
  endfunction

  // monitor / scoreboard on instance 0
  always @(negedge clk) begin
    if (resetn && (rf_we[0] | csr_we[0] | exc_commit[0] | ertn_commit[0] | ws_flush[0])) begin
      logic [EW-1:0] act, exp;
      act = observe();
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %h expected none", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL retire_event: got %h expected %h", act, exp);
        end
      end
    end
  end

  // driver: called at a negedge; returns at the negedge after acceptance by instance 0
  task automatic send(input in_t ins, input ev_t exp_ev, output int waits);
    waits = 0;
    exp_q.push_back(exp_ev);
    m_in = ins;
    m_valid = 1'b1;
    while (!allowin[0] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!allowin[0]) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got allowin 0 expected 1");
    end
    @(negedge clk);
    m_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int w;
    int stalls [NI];

    // reset state
    #1;
    chk("rst_allowin", 64'(allowin), 64'h7);
    chk("rst_flush", 64'(ws_flush), 64'h0);
    chk("rst_rf_we", 64'(rf_we), 64'h0);
    chk("rst_dbg_pc", 64'(dbg_pc[0]), 64'h0);
    chk("rst_state", 64'(dbg_state[0]), 64'(RUN));
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    idle(2);

    // back-to-back ALU retire
    send(i_alu(32'h1C00_0000, 5'd5, 32'h11), e_rf(32'h1C00_0000, 5'd5, 32'h11, 1'b1, 5'd5, 32'h11), w);
    chk("b2b_wait0", 64'(w), 64'd0);
    send(i_alu(32'h1C00_0004, 5'd6, 32'h22), e_rf(32'h1C00_0004, 5'd6, 32'h22, 1'b1, 5'd6, 32'h22), w);
    chk("b2b_wait1", 64'(w), 64'd0);
    // r0 write: RF write still issued, no forwarding
    send(i_alu(32'h1C00_0008, 5'd0, 32'h33), e_rf(32'h1C00_0008, 5'd0, 32'h33, 1'b0, 5'd0, 32'h0), w);
    // CSR write
    send(i_csr(32'h1C00_000C, 14'h006, 32'h0000_00FF, 32'hAB),
         e_csr(32'h1C00_000C, 14'h006, 32'h0000_00FF, 32'hAB), w);
    idle(3);

    // exception: count allowin-low cycles on all instances from the flush cycle
    send(i_trap(32'h1C00_0100, 1'b1, 1'b0, 6'h0B, 9'h0, 32'h0),
         e_trap(1'b1, 1'b0, 6'h0B, 9'h0, 32'h1C00_0100, 32'h0), w);
    for (int g = 0; g < NI; g++) stalls[g] = 0;
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < NI; g++) if (!allowin[g]) stalls[g]++;
      @(negedge clk);
    end
    chk("stall_fh1", 64'(stalls[0]), 64'd2);
    chk("stall_fh0", 64'(stalls[1]), 64'd1);
    chk("stall_fh3", 64'(stalls[2]), 64'd4);

    // exc and ertn together: exc wins; then ertn alone
    send(i_trap(32'h1C00_0200, 1'b1, 1'b1, 6'h0D, 9'h1, 32'h1234_5678),
         e_trap(1'b1, 1'b0, 6'h0D, 9'h1, 32'h1C00_0200, 32'h1234_5678), w);
    idle(8);
    send(i_trap(32'h1C00_0300, 1'b0, 1'b1, 6'h0, 9'h0, 32'h0),
         e_trap(1'b0, 1'b1, 6'h0, 9'h0, 32'h0, 32'h0), w);
    // follow-up offered during the flush cycle waits out flush + hold
    send(i_alu(32'h1C00_0304, 5'd7, 32'h77), e_rf(32'h1C00_0304, 5'd7, 32'h77, 1'b1, 5'd7, 32'h77), w);
    chk("post_trap_wait", 64'(w), 64'd2);
    idle(8);

    // async reset while in HOLD
    send(i_trap(32'h1C00_0400, 1'b1, 1'b0, 6'h08, 9'h0, 32'h1C00_0401),
         e_trap(1'b1, 1'b0, 6'h08, 9'h0, 32'h1C00_0400, 32'h1C00_0401), w);
    @(negedge clk);
    chk("hold_state", 64'(dbg_state[2]), 64'(HOLD));
    chk("hold_allowin", 64'(allowin[2]), 64'd0);
    #2 resetn = 1'b0;
    #1;
    chk("arst_allowin", 64'(allowin), 64'h7);
    chk("arst_state", 64'(dbg_state[2]), 64'(RUN));
    chk("arst_commit", 64'({exc_commit, ertn_commit, ws_flush}), 64'h0);
    chk("arst_writes", 64'({rf_we, csr_we, csr_busy, fwd_v}), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    idle(4);
    send(i_alu(32'h1C00_0500, 5'd31, 32'hCAFE_F00D),
         e_rf(32'h1C00_0500, 5'd31, 32'hCAFE_F00D, 1'b1, 5'd31, 32'hCAFE_F00D), w);
    chk("after_rst_wait", 64'(w), 64'd0);
    idle(4);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
